// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display driver: segment bit positions
// and the hex glyph table (bit 0 = segment a ... bit 6 = segment g).
package seven_segment_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam int unsigned SEG_COUNT = 8;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

endpackage

// File: rtl/seven_segment_multiplexer_if.sv
// Load port of the display driver: a frame of nibbles, decimal points and the
// leading-zero flag, transferred with a valid/ready handshake.
interface seven_segment_multiplexer_if #(
  parameter int NUM_DIGITS = 8
);

  logic [NUM_DIGITS*4-1:0] data;
  logic [NUM_DIGITS-1:0]   pointEnable;
  logic                    suppressZeros;
  logic                    loadValid;
  logic                    loadReady;

  modport master (
    output data,
    output pointEnable,
    output suppressZeros,
    output loadValid,
    input  loadReady
  );

  modport slave (
    input  data,
    input  pointEnable,
    input  suppressZeros,
    input  loadValid,
    output loadReady
  );

endinterface

// File: rtl/seven_segment_glyph.sv
// Combinational hex nibble plus decimal point to active-high segment mask.
module seven_segment_glyph
  import seven_segment_pkg::*;
(
  input  logic [3:0]           nibble,
  input  logic                 point,
  output logic [SEG_COUNT-1:0] segment_mask
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    segment_mask                = '0;
    segment_mask[SEG_G:SEG_A]   = HEX_GLYPH[nibble];
    segment_mask[SEG_DP]        = point;
  end

endmodule

// File: rtl/seven_segment_multiplexer.sv
// Time-multiplexed seven-segment scanner with double-buffered frame loads,
// inter-digit blanking, PWM brightness, leading-zero blanking and output polarity.
module seven_segment_multiplexer
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS         = 8,
  parameter int SLOT_CYCLES        = 12500,
  parameter int BLANK_CYCLES       = 64,
  parameter int BRIGHTNESS_BITS    = 4,
  parameter bit SEGMENT_ACTIVE_LOW = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  seven_segment_multiplexer_if.slave  load,
  input  logic [BRIGHTNESS_BITS-1:0]  brightness,
  output logic                        frameStart,
  output logic [SEG_COUNT-1:0]        segmentEnableN,
  output logic [NUM_DIGITS-1:0]       digitEnableN
);

  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [SLOT_W-1:0]          SLOT_LAST   = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]          BLANK_END   = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIGIT_W-1:0]         DIGIT_LAST  = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHTNESS_BITS-1:0] BRIGHT_FULL = '1;
  localparam logic [SEG_COUNT-1:0]       SEG_OFF     = SEGMENT_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0]      DIGIT_OFF   = DIGIT_ACTIVE_LOW ? '1 : '0;

  typedef struct packed {
    logic [NUM_DIGITS*4-1:0] data;
    logic [NUM_DIGITS-1:0]   points;
    logic                    suppress;
  } frame_buf_t;

  logic [SLOT_W-1:0]          slot_count_q, slot_count_d;
  logic [DIGIT_W-1:0]         digit_q, digit_d;
  logic [BRIGHTNESS_BITS-1:0] pwm_count_q, pwm_count_d;
  logic                       pending_q, pending_d;
  logic                       load_ready_q, load_ready_d;
  logic                       frame_start_q, frame_start_d;
  frame_buf_t                 shadow_q, shadow_d;
  frame_buf_t                 active_q, active_d;
  logic [SEG_COUNT-1:0]       segment_q, segment_d;
  logic [NUM_DIGITS-1:0]      digit_en_q, digit_en_d;

  logic                       boundary;
  logic                       load_fire;
  logic [NUM_DIGITS-1:0]      suppressed;
  logic                       zero_run;
  logic [3:0]                 cur_nibble;
  logic                       cur_point;
  logic                       cur_suppressed;
  logic                       lit;
  logic [SEG_COUNT-1:0]       glyph_mask;
  logic [SEG_COUNT-1:0]       seg_logic;
  logic [NUM_DIGITS-1:0]      dig_logic;

  assign boundary  = (slot_count_q == '0) && (digit_q == '0);
  assign load_fire = load.loadValid && load_ready_q;

  // Scan counters: slot position inside a digit, digit index, PWM phase.
  always_comb begin
    slot_count_d = slot_count_q + 1'b1;
    digit_d      = digit_q;
    pwm_count_d  = pwm_count_q + 1'b1;
    if (slot_count_q == SLOT_LAST) begin
      slot_count_d = '0;
      digit_d      = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
    end
  end

  // Double buffer: a pending shadow frame is promoted only at a frame boundary,
  // so a frame is never shown half old and half new.
  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load_fire) begin
      shadow_d.data     = load.data;
      shadow_d.points   = load.pointEnable;
      shadow_d.suppress = load.suppressZeros;
      pending_d         = 1'b1;
    end
    load_ready_d  = ~pending_d;
    frame_start_d = boundary;
  end

  // Leading-zero run is tracked from the most significant digit downwards.
  always_comb begin
    suppressed = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (active_q.data[i*4 +: 4] == 4'h0) && !active_q.points[i];
      suppressed[i] = active_q.suppress && (i != 0) && zero_run;
    end
  end

  always_comb begin
    cur_nibble     = '0;
    cur_point      = 1'b0;
    cur_suppressed = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DIGIT_W'(i)) begin
        cur_nibble     = active_q.data[i*4 +: 4];
        cur_point      = active_q.points[i];
        cur_suppressed = suppressed[i];
      end
    end
  end

  seven_segment_glyph u_glyph (
    .nibble       (cur_nibble),
    .point        (cur_point),
    .segment_mask (glyph_mask)
  );

  always_comb begin
    lit = (slot_count_q >= BLANK_END)
       && ((brightness == BRIGHT_FULL) || (pwm_count_q < brightness))
       && !cur_suppressed;
    seg_logic = lit ? glyph_mask : '0;
    dig_logic = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_logic[i] = lit && (digit_q == DIGIT_W'(i));
    end
    segment_d  = SEGMENT_ACTIVE_LOW ? ~seg_logic : seg_logic;
    digit_en_d = DIGIT_ACTIVE_LOW ? ~dig_logic : dig_logic;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_count_q  <= '0;
      digit_q       <= '0;
      pwm_count_q   <= '0;
      pending_q     <= 1'b0;
      load_ready_q  <= 1'b1;
      frame_start_q <= 1'b0;
      // NOTE: the frame buffers are plain flops, not a RAM, so resetting them
      // is cheap and guarantees a blank, deterministic display after reset.
      shadow_q      <= '0;
      active_q      <= '0;
      segment_q     <= SEG_OFF;
      digit_en_q    <= DIGIT_OFF;
    end else begin
      slot_count_q  <= slot_count_d;
      digit_q       <= digit_d;
      pwm_count_q   <= pwm_count_d;
      pending_q     <= pending_d;
      load_ready_q  <= load_ready_d;
      frame_start_q <= frame_start_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      segment_q     <= segment_d;
      digit_en_q    <= digit_en_d;
    end
  end

  assign load.loadReady = load_ready_q;
  assign frameStart     = frame_start_q;
  assign segmentEnableN = segment_q;
  assign digitEnableN   = digit_en_q;

endmodule

// File: tb/tb_seven_segment_multiplexer.sv
// Directed and randomized self-checking bench for seven_segment_multiplexer
// (4 digits, 16-cycle slots, 2 blank cycles, 2-bit brightness, active-low).
module tb_seven_segment_multiplexer;

  localparam int NUM_DIGITS   = 4;
  localparam int SLOT_CYCLES  = 16;
  localparam int BLANK_CYCLES = 2;
  localparam int BRIGHT_BITS  = 2;
  localparam int FRAME        = NUM_DIGITS * SLOT_CYCLES;

  logic                   clock;
  logic                   reset;
  logic [BRIGHT_BITS-1:0] brightness;
  logic                   frameStart;
  logic [7:0]             segmentEnableN;
  logic [NUM_DIGITS-1:0]  digitEnableN;

  seven_segment_multiplexer_if #(.NUM_DIGITS(NUM_DIGITS)) load_if ();

  seven_segment_multiplexer #(
    .NUM_DIGITS         (NUM_DIGITS),
    .SLOT_CYCLES        (SLOT_CYCLES),
    .BLANK_CYCLES       (BLANK_CYCLES),
    .BRIGHTNESS_BITS    (BRIGHT_BITS),
    .SEGMENT_ACTIVE_LOW (1'b1),
    .DIGIT_ACTIVE_LOW   (1'b1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .load           (load_if),
    .brightness     (brightness),
    .frameStart     (frameStart),
    .segmentEnableN (segmentEnableN),
    .digitEnableN   (digitEnableN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Walk frame cycles first_c..FRAME (cycle 1 = frameStart high) and compare
  // {frameStart, segments, digits}; exp_seg holds active-low glyphs {d3,d2,d1,d0}.
  task automatic check_frame(input int first_c, input logic [31:0] exp_seg,
                             input logic [3:0] lit_mask, input int b, output int on_cnt);
    logic [3:0]  dsel;
    logic [12:0] exp;
    int s, d, p;
    bit on;
    on_cnt = 0;
    for (int c = first_c; c <= FRAME; c++) begin
      s    = (c - 1) % SLOT_CYCLES;
      d    = (c - 1) / SLOT_CYCLES;
      p    = (c - 1) % 4;
      on   = (s >= BLANK_CYCLES) && lit_mask[d] && ((b == 3) || (p < b));
      dsel = 4'b0001 << d;
      exp  = on ? {(c == 1), exp_seg[d*8 +: 8], ~dsel} : {(c == 1), 8'hFF, 4'hF};
      check($sformatf("frame_c%0d", c), {frameStart, segmentEnableN, digitEnableN}, exp);
      if (digitEnableN != 4'hF) on_cnt++;
      @(negedge clock);
    end
  endtask

  task automatic wait_frame_start();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frameStart && n < 200);
    if (!frameStart) check("frame_start_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] pe, input logic sz);
    check("ready_before_load", load_if.loadReady, 1);
    load_if.data          = d;
    load_if.pointEnable   = pe;
    load_if.suppressZeros = sz;
    load_if.loadValid     = 1'b1;
    @(negedge clock);
    load_if.loadValid = 1'b0;
    check("ready_after_load", load_if.loadReady, 0);
  endtask

  // Continuous invariants during the randomized phase.
  bit mon_en   = 0;
  bit have_fs  = 0;
  int cyc      = 0;
  int last_fs  = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      check("one_digit_max", 32'($countones(~digitEnableN) <= 1), 1);
      if (frameStart) begin
        if (have_fs) check("frame_spacing", cyc - last_fs, FRAME);
        last_fs = cyc;
        have_fs = 1;
      end
      cyc++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int on;
    int ready_seen;
    int n;

    reset                 = 1'b1;
    brightness            = 2'd3;
    load_if.data          = '0;
    load_if.pointEnable   = '0;
    load_if.suppressZeros = 1'b0;
    load_if.loadValid     = 1'b0;

    repeat (2) @(negedge clock);
    check("reset_segments", segmentEnableN, 8'hFF);
    check("reset_digits", digitEnableN, 4'hF);
    check("reset_ready", load_if.loadReady, 1);
    check("reset_frame_start", frameStart, 0);

    reset = 1'b0;
    @(negedge clock);
    check("first_frame_start", frameStart, 1);

    // Full brightness, all digits: F A 2 1 from right to left.
    do_load(16'h12AF, 4'h0, 1'b0);
    wait_frame_start();
    check_frame(1, 32'hF9A4888E, 4'hF, 3, on);
    check("on_cycles_12AF", on, 56);

    // Leading-zero blanking: only digit 0 stays lit.
    do_load(16'h0000, 4'h0, 1'b1);
    wait_frame_start();
    check_frame(1, 32'hFFFFFFC0, 4'b0001, 3, on);
    check("on_cycles_sup_all", on, 14);

    // A decimal point on digit 2 stops the blanking run there.
    do_load(16'h0000, 4'b0100, 1'b1);
    wait_frame_start();
    check_frame(1, 32'hFF40C0C0, 4'b0111, 3, on);
    check("on_cycles_sup_dp", on, 42);

    // loadValid held across two words: second accepted right after the boundary.
    check("ready_before_pair", load_if.loadReady, 1);
    load_if.data          = 16'h3456;
    load_if.pointEnable   = 4'h0;
    load_if.suppressZeros = 1'b0;
    load_if.loadValid     = 1'b1;
    @(negedge clock);
    check("ready_low_after_first", load_if.loadReady, 0);
    load_if.data = 16'h789C;
    ready_seen   = 0;
    n            = 0;
    do begin
      @(negedge clock);
      n++;
      if (!frameStart && load_if.loadReady) ready_seen++;
    end while (!frameStart && n < 200);
    check("pair_frame_start_seen", frameStart, 1);
    check("ready_stayed_low", ready_seen, 0);
    check("ready_at_frame_start", load_if.loadReady, 1);
    @(negedge clock);
    load_if.loadValid = 1'b0;
    check("ready_low_after_second", load_if.loadReady, 0);
    check_frame(2, 32'hB0999282, 4'hF, 3, on);
    check("on_cycles_first_word", on, 56);
    check_frame(1, 32'hF88090C6, 4'hF, 3, on);
    check("on_cycles_second_word", on, 56);

    // PWM: brightness 1 lights one cycle in four; brightness 0 is dark.
    brightness = 2'd1;
    check_frame(1, 32'hF88090C6, 4'hF, 1, on);
    check("on_cycles_bright1", on, 12);
    brightness = 2'd0;
    check_frame(1, 32'hF88090C6, 4'hF, 0, on);
    check("on_cycles_bright0", on, 0);
    brightness = 2'd3;

    // Reset mid-slot on digit 2 with a load pending.
    do_load(16'hDEAD, 4'hF, 1'b0);
    repeat (38) @(negedge clock);
    check("digit2_lit_before_reset", {segmentEnableN, digitEnableN}, {8'h80, 4'b1011});
    reset = 1'b1;
    #1;
    check("midreset_segments", segmentEnableN, 8'hFF);
    check("midreset_digits", digitEnableN, 4'hF);
    check("midreset_ready", load_if.loadReady, 1);
    check("midreset_frame_start", frameStart, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_frame(1, 32'hC0C0C0C0, 4'hF, 3, on);
    check("on_cycles_after_reset", on, 56);

    // Randomized loads and brightness with continuous invariant checks.
    mon_en = 1;
    for (int i = 0; i < 1000; i++) begin
      load_if.data          = 16'($urandom);
      load_if.pointEnable   = 4'($urandom_range(0, 15));
      load_if.suppressZeros = 1'($urandom_range(0, 1));
      brightness            = 2'($urandom_range(0, 3));
      load_if.loadValid     = 1'b1;
      n = 0;
      while (!load_if.loadReady && n < 200) begin
        @(negedge clock);
        n++;
      end
      if (!load_if.loadReady) begin
        check("random_handshake_timeout", 0, 1);
        break;
      end
      @(negedge clock);
      load_if.loadValid = 1'b0;
    end
    mon_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_multiplexer.md
# seven_segment_multiplexer

- Parametrised, time-multiplexed seven-segment display driver for shared-segment, per-digit-enable displays such as the Nexys A7 eight-digit array.
- Scans NUM_DIGITS hex digits and adds features beyond a plain scanner: per-frame double-buffered data loads with a valid/ready handshake, anti-ghosting blank time between digits, global PWM brightness, leading-zero suppression and configurable output polarity.
- Sits between the application's display-value registers and the board pins.

## Interface
- NUM_DIGITS, 8: digits scanned; must be ≥1.
- SLOT_CYCLES, 12500: clock cycles per digit slot (1 kHz frame at 100 MHz, 8 digits); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digits off.
- BRIGHTNESS_BITS, 4: brightness input width.
- SEGMENT_ACTIVE_LOW, 1: segment output polarity.
- DIGIT_ACTIVE_LOW, 1: digit output polarity.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- data  in  NUM_DIGITS*4  nibble i drives digit i; digit 0 is rightmost.
- pointEnable  in  NUM_DIGITS  decimal point per digit, active-high.
- suppressZeros  in  1  leading-zero blanking enable.
- loadValid  in  1  data/pointEnable/suppressZeros valid.
- loadReady  out  1  shadow buffer free.
- brightness  in  BRIGHTNESS_BITS  live, not buffered; 0 = dark, all-ones = full.
- frameStart  out  1  one-cycle pulse at each frame boundary.
- segmentEnableN  out  8  bit 0..6 = a..g, bit 7 = dp.
- digitEnableN  out  NUM_DIGITS  one-hot digit select.

## Operation
- Load handshake: a load transfers when loadValid and loadReady are both high on a clock edge.
  - The transfer captures data, pointEnable and suppressZeros into the shadow buffer and sets pending.
  - loadReady = ~pending, registered.
- Frame boundary: the cycle where slotCount==0 and digit==0.
  - If pending, active buffer ← shadow and pending clears.
  - frameStart is high on this cycle.
  - A load accepted on the same cycle goes to the shadow and is applied at the next boundary.
- Counters: slotCount runs 0..SLOT_CYCLES-1. When it wraps, digit advances 0..NUM_DIGITS-1 and then wraps to 0.
  - Digit index width is $clog2(NUM_DIGITS), minimum 1.
  - pwmCount is a free-running BRIGHTNESS_BITS counter.
- A digit is lit iff all of the following hold:
  - slotCount ≥ BLANK_CYCLES;
  - brightness==all-ones or pwmCount < brightness;
  - the digit is not suppressed.
- Suppression: digit i is suppressed iff all of the following hold:
  - suppressZeros is set;
  - i≠0;
  - nibbles i..NUM_DIGITS-1 are all zero;
  - point bits i..NUM_DIGITS-1 are all clear.
- Unlit slot: segments and digits are all inactive.
- Lit slot: only the selected digit is active; segments carry the hex glyph 0–F plus dp from the active buffer.
- Polarity: logical active-high values are inverted at the output register when the matching ACTIVE_LOW parameter is set.

## Timing
- Reset (asynchronous, immediate):
  - segments and digits inactive (both 8'hFF / all-ones with default parameters);
  - loadReady=1, frameStart=0;
  - pending=0, active and shadow buffers zero;
  - all counters 0.
- First frameStart: the first clock edge after reset deasserts.
- Outputs are registered with 1-cycle latency from counter state.
  - Digit d therefore lights from cycle d*SLOT_CYCLES+BLANK_CYCLES+1 after the boundary, when brightness is full.
- Frame period is NUM_DIGITS*SLOT_CYCLES cycles.
- Load-to-display latency: from a handshake to the next boundary, plus 1 cycle.
- A brightness change takes effect on the next cycle.
- No glitch is allowed: at most one digit is ever active; segment and digit changes happen on the same edge.
- Reset mid-frame discards any pending load; scanning restarts at digit 0.

## Structure
- Package seven_segment_pkg holds:
  - the 16-entry hex glyph constant (a..g order);
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP).
- Sub-module seven_segment_glyph: combinational nibble+dp → 8-bit active-high segment mask.
- All sequencing, buffering, suppression and PWM stay in the top module.

## Test plan
Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=16, BLANK_CYCLES=2, BRIGHTNESS_BITS=2, active-low.

- Reset, then load data=16'h12AF, brightness=3.
  - Digit 0 shows F (segments 8'b1000_1110) with digitEnableN=4'b1110 for cycles 3–16 of the frame.
  - digitEnableN=4'hF during the blank cycles.
- Load data=16'h0000 pointEnable=0 with suppressZeros=1 → only digit 0 ever lit, showing 0.
  - Repeat with pointEnable=4'b0100 → digits 0–2 are lit.
- Hold loadValid high with two different words → first accepted, loadReady low until frameStart.
  - Second accepted on the boundary cycle and displayed one frame later.
- brightness=1 → each lit slot's on-window is active exactly every 4th cycle.
  - brightness=0 → digitEnableN stays 4'hF for the whole frame.
- Assert reset mid-slot on digit 2 → outputs inactive within the same cycle, loadReady=1, pending load lost.
  - Next frameStart on the first edge after release.
- Over 1000 random loads and brightness values, check every cycle:
  - at most one digitEnableN bit is low;
  - frameStart spacing is exactly 64 cycles.
